// File: rtl/row_mean_sequencer.sv
// row_mean_sequencer: streams a SIZE_A x SIZE_B matrix row-major through one
// shared accumulator and emits one truncated mean per row on a valid/ready port.
module row_mean_sequencer #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 22,
    localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_data,
    output logic [ROW_W-1:0]  out_row
);

    localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam int ACC_W = N_BITS + $clog2(SIZE_B);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SIZE_B - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SIZE_A - 1);
    localparam logic [ACC_W-1:0] DIVISOR  = ACC_W'(SIZE_B);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIV,
        EMIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [N_BITS-1:0]  out_data_q, out_data_d;
    logic [ROW_W-1:0]   out_row_q, out_row_d;

    // State, counters, accumulator and output registers; reset discards any partial pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
        end
    end

    // Next-state logic: accumulate a row, divide once, hold the mean until accepted.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + ACC_W'(in_data);
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = DIV;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DIV: begin
                // Quotient of a row sum always fits in N_BITS, so the cast only drops zero bits.
                out_data_d = N_BITS'(acc_q / DIVISOR);
                out_row_d  = row_q;
                acc_d      = '0;
                state_d    = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                row_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered or decoded from state only.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == EMIT);
        out_data  = out_data_q;
        out_row   = out_row_q;
    end

endmodule

// File: tb/tb_row_mean_sequencer.sv
// tb_row_mean_sequencer: directed passes with random matrices, checked against
// row sums computed directly from the stimulus matrix.
module tb_row_mean_sequencer;

    localparam int SA = 8;
    localparam int SB = 8;
    localparam int NB = 22;
    localparam int RW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] out_data;
    logic [RW-1:0] out_row;

    int n_cmp;
    int n_bad;
    int cyc;

    logic [NB-1:0] mat [SA][SB];

    row_mean_sequencer #(
        .SIZE_A (SA),
        .SIZE_B (SB),
        .N_BITS (NB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running count of rising edges for pass-time measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                mat[r][c] = NB'($urandom);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_row"}, out_row, 0);
    endtask

    // One matrix pass. bubbles: toggle in_valid; bp: hold out_ready low 5 cycles per EMIT;
    // inj: pulse start in ACCUM, EMIT and DONE; rst_row: reset during that row (-1 = none);
    // timed: check the start-to-done distance for the stall-free case.
    task automatic run_pass(input bit bubbles, input bit bp, input bit inj,
                            input int rst_row, input bit timed);
        int c;
        int start_cyc;
        int vt;
        logic [63:0]   sum;
        logic [NB-1:0] exp_mean;

        vt = 0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        start     = 1'b1;
        out_ready = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;

        for (int r = 0; r < SA; r++) begin
            sum = 0;
            for (int k = 0; k < SB; k++) sum += 64'(mat[r][k]);
            exp_mean = NB'(sum / SB);

            c = 0;
            while (c < SB) begin
                start = inj && (r == 1) && (c == 3);
                chk("accum_in_ready", in_ready, 1);
                chk("accum_busy", busy, 1);
                chk("accum_out_valid", out_valid, 0);
                chk("accum_done", done, 0);
                if (r == rst_row && c == 2) begin
                    rst_n = 1'b0;
                    #1;
                    chk_reset_values("midreset");
                    start    = 1'b0;
                    in_valid = 1'b0;
                    @(negedge clk);
                    chk_reset_values("midreset_hold");
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk("midreset_idle_busy", busy, 0);
                    return;
                end
                in_valid = bubbles ? (vt % 2 == 0) : 1'b1;
                vt++;
                in_data  = in_valid ? mat[r][c] : NB'($urandom);
                @(posedge clk);
                if (in_valid) c++;
                @(negedge clk);
            end

            // DIV cycle: offer a junk element that must not be taken.
            start     = 1'b0;
            in_valid  = 1'b1;
            in_data   = NB'($urandom);
            out_ready = bp ? 1'b0 : 1'b1;
            chk("div_in_ready", in_ready, 0);
            chk("div_out_valid", out_valid, 0);
            chk("div_busy", busy, 1);
            @(negedge clk);

            start = inj && (r == 2);
            chk("emit_out_valid", out_valid, 1);
            chk("emit_out_data", out_data, exp_mean);
            chk("emit_out_row", out_row, r);
            chk("emit_in_ready", in_ready, 0);
            chk("emit_done", done, 0);
            if (bp) begin
                repeat (4) begin
                    @(negedge clk);
                    start   = 1'b0;
                    in_data = NB'($urandom);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_data", out_data, exp_mean);
                    chk("stall_out_row", out_row, r);
                    chk("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
        end

        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_in_ready", in_ready, 0);
        chk("done_out_valid", out_valid, 0);
        // done is high in the SA*(SB+2)+1-th cycle counted from the cycle start was high
        if (timed) chk("pass_time", cyc - start_cyc, SA * (SB + 2) + 1);
        start = inj;
        @(negedge clk);
        start = 1'b0;
        chk("after_done", done, 0);
        chk("after_done_busy", busy, 0);
        @(negedge clk);
        chk("idle_stays_busy", busy, 0);
        chk("idle_stays_done", done, 0);
        chk("idle_no_valid", out_valid, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Default pattern: row r is all 10*r+5, back to back.
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                mat[r][c] = NB'(10 * r + 5);
        run_pass(1'b0, 1'b0, 1'b0, -1, 1'b1);

        // Truncation and full-scale row.
        fill_random();
        for (int c = 0; c < SB; c++) mat[0][c] = NB'(1);
        mat[0][SB-1] = NB'(2);
        for (int c = 0; c < SB; c++) mat[1][c] = 22'h3FFFFF;
        run_pass(1'b0, 1'b0, 1'b0, -1, 1'b1);

        // Input bubbles.
        fill_random();
        run_pass(1'b1, 1'b0, 1'b0, -1, 1'b0);

        // Output backpressure.
        fill_random();
        run_pass(1'b0, 1'b1, 1'b0, -1, 1'b0);

        // Mid-pass reset after three rows, then a clean full pass.
        fill_random();
        run_pass(1'b0, 1'b0, 1'b0, 3, 1'b0);
        fill_random();
        run_pass(1'b0, 1'b0, 1'b0, -1, 1'b1);

        // Ignored start pulses, with bubbles and backpressure mixed in.
        fill_random();
        run_pass(1'b0, 1'b0, 1'b1, -1, 1'b1);
        fill_random();
        run_pass(1'b1, 1'b1, 1'b1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
